// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: read-return tag layout and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_port_arbiter_pkg;

  // Tag ids are sized for the largest supported requester count (4).
  localparam int MAX_REQ          = 4;
  localparam int TAG_ID_W         = $clog2(MAX_REQ);
  localparam int LOCK_MAX_DEFAULT = 8;

  // One in-flight read: valid bit plus owning requester index.
  typedef struct packed {
    logic                vld;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Rotating-priority pick: first requester at or after ptr, wrapping, gets the one-hot grant.
// Latency: purely combinational.
// Backpressure: none; a requester that is not picked simply stays pending.
module mem_port_arbiter_rr_arbiter #(
  parameter int N  = 2,
  parameter int PW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic          found;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;

  // Scan ptr, ptr+1, ... modulo N and grant the first requester found.
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int off = 0; off < N; off++) begin
      sum = {1'b0, ptr} + (PW+1)'(off);
      if (sum >= (PW+1)'(N)) begin
        sum = sum - (PW+1)'(N);
      end
      idx = sum[PW-1:0];
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one RAM port among NUM_REQ requesters: round-robin with bounded burst lock, registered issue, tagged read return.
// Latency: gnt same cycle as req; mem_* one cycle after gnt; rvalid/rdata READ_LAT+1 cycles after gnt.
// Backpressure: a requester holds req and its fields until it sees gnt; ungranted requesters wait, returns are never stalled.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ADDR_BITS = 16,
  parameter int NUM_REQ   = 2,
  parameter int READ_LAT  = 1,
  parameter int LOCK_MAX  = LOCK_MAX_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ-1:0]            req_lock,
  input  logic [NUM_REQ*ADDR_BITS-1:0]  req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [WIDTH-1:0]              rdata,
  output logic [ADDR_BITS-1:0]          mem_addr,
  output logic                          mem_we,
  output logic [WIDTH-1:0]              mem_wdata,
  input  logic [WIDTH-1:0]              mem_q
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(LOCK_MAX + 1);

  // Out-of-range configurations stop elaboration.
  generate
    if ((NUM_REQ < 2) || (NUM_REQ > 4) || (READ_LAT < 1) || (READ_LAT > 3)) begin : g_bad_params
      $error("mem_port_arbiter: NUM_REQ must be 2..4 and READ_LAT 1..3");
    end
  endgenerate

  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic                 lock_vld_q, lock_vld_d;
  logic [ID_W-1:0]      lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]     lock_cnt_q, lock_cnt_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic                 mem_we_q, mem_we_d;
  logic [WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [NUM_REQ-1:0]   rvalid_q, rvalid_d;
  logic [WIDTH-1:0]     rdata_q, rdata_d;
  tag_t                 tag_q [READ_LAT];
  tag_t                 tag_d [READ_LAT];

  logic [NUM_REQ-1:0]   rr_gnt;
  logic [NUM_REQ-1:0]   gnt_w;
  logic                 lock_hit;
  logic                 gnt_any;
  logic [ID_W-1:0]      g_idx;
  logic [CNT_W-1:0]     run_cnt;
  tag_t                 tag_out;

  mem_port_arbiter_rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rr_arbiter (
    .req (req),
    .ptr (rr_ptr_q),
    .gnt (rr_gnt)
  );

  // Grant selection: an unexpired lock owner that still requests with lock wins, else round-robin.
  always_comb begin
    lock_hit = lock_vld_q && req[lock_owner_q] && req_lock[lock_owner_q]
               && (lock_cnt_q < CNT_W'(LOCK_MAX));
    gnt_w = rr_gnt;
    if (lock_hit) begin
      gnt_w               = '0;
      gnt_w[lock_owner_q] = 1'b1;
    end
    gnt_any = |gnt_w;
    g_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_w[i]) begin
        g_idx = ID_W'(i);
      end
    end
  end

  assign gnt = gnt_w;

  // Next-state for pointer, lock run, issue registers, tag pipeline and return stage.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    lock_vld_d   = lock_vld_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = 1'b0;
    run_cnt      = '0;

    if (gnt_any) begin
      rr_ptr_d    = (int'(g_idx) == NUM_REQ - 1) ? '0 : g_idx + 1'b1;
      mem_addr_d  = req_addr[int'(g_idx)*ADDR_BITS +: ADDR_BITS];
      mem_wdata_d = req_wdata[int'(g_idx)*WIDTH +: WIDTH];
      mem_we_d    = req_we[g_idx];

      if (req_lock[g_idx]) begin
        // Continue the run only if this requester already owned the lock.
        run_cnt = (lock_vld_q && (lock_owner_q == g_idx)) ? lock_cnt_q + 1'b1 : CNT_W'(1);
        if (run_cnt >= CNT_W'(LOCK_MAX)) begin
          // Run exhausted: next grant goes through round-robin.
          lock_vld_d = 1'b0;
          lock_cnt_d = '0;
        end else begin
          lock_vld_d   = 1'b1;
          lock_owner_d = g_idx;
          lock_cnt_d   = run_cnt;
        end
      end else begin
        lock_vld_d = 1'b0;
        lock_cnt_d = '0;
      end
    end

    // Tags travel alongside the RAM access; the last stage lines up with valid mem_q.
    tag_d[0].vld = gnt_any && !req_we[g_idx];
    tag_d[0].id  = TAG_ID_W'(g_idx);
    for (int k = 1; k < READ_LAT; k++) begin
      tag_d[k] = tag_q[k-1];
    end

    tag_out = tag_q[READ_LAT-1];
    for (int i = 0; i < NUM_REQ; i++) begin
      rvalid_d[i] = tag_out.vld && (tag_out.id == TAG_ID_W'(i));
    end
    rdata_d = tag_out.vld ? mem_q : rdata_q;
  end

  // State registers with synchronous active-low reset; reset drops all in-flight tags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr_q     <= '0;
      lock_vld_q   <= 1'b0;
      lock_owner_q <= '0;
      lock_cnt_q   <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
      for (int k = 0; k < READ_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      lock_vld_q   <= lock_vld_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      for (int k = 0; k < READ_LAT; k++) begin
        tag_q[k] <= tag_d[k];
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;

endmodule
